// File: rtl/lc3_fetch.sv
// lc3_fetch: LC-3 instruction fetch FSM with a single outstanding memory request,
// a one-entry IR holding register and branch redirect/flush handling.
module lc3_fetch #(
  parameter logic [15:0] RESET_PC = 16'h3000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] pc,
  output logic        instrmem_rd,
  input  logic [15:0] Instr_dout,
  input  logic        complete_instr,
  input  logic        br_taken,
  input  logic [15:0] taddr,
  output logic [15:0] IR,
  output logic [15:0] npc,
  output logic        IR_valid,
  input  logic        IR_ready
);
  typedef enum logic [2:0] {IDLE, REQ, RESP, HOLD, FLUSH} state_t;
  state_t state, state_nxt;
  logic capture;
  logic accept;
  always_comb begin
    accept = state == HOLD && IR_ready;
    capture = state == RESP && complete_instr && !br_taken;
    instrmem_rd = (state == REQ || accept) && !br_taken;
    state_nxt = state;
    if (br_taken)
      // a redirect with a request still in flight must drain it before re-requesting
      state_nxt = ((state == RESP || state == FLUSH) && !complete_instr) ? FLUSH : REQ;
    else
      case (state)
        IDLE:    state_nxt = REQ;
        REQ:     state_nxt = RESP;
        RESP:    state_nxt = complete_instr ? HOLD : RESP;
        HOLD:    state_nxt = IR_ready ? RESP : HOLD;
        FLUSH:   state_nxt = complete_instr ? REQ : FLUSH;
        default: state_nxt = IDLE;
      endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      pc <= RESET_PC;
      npc <= RESET_PC;
      IR <= 16'h0000;
      IR_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      pc <= br_taken ? taddr : capture ? pc + 16'd1 : pc;
      IR_valid <= br_taken ? 1'b0 : capture ? 1'b1 : accept ? 1'b0 : IR_valid;
      if (capture) begin
        IR <= Instr_dout;
        npc <= pc + 16'd1;
      end
    end
  end
endmodule
